window_serializer: RTL and testbench
====================================

# window_serializer

Converts one parallel window of winRow×winCol pixels back into a raster-order pixel stream, one pixel per accepted beat. It is the inverse of the scan-line buffer's parallel window output: a processing stage writes a full window (same packing as the scan-line buffer's parallel output), and this block replays it serially to a downstream consumer. Ready/valid handshakes are used on both sides, with a global enable stall.

## Interface
Parameters:
- winCol, 42, window width in pixels
- winRow, 42, window height in pixels
- bitwidth, 30, bits per pixel

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  global stall; when low, no state changes and no handshake completes
- windowIn  in  winRow*winCol*bitwidth  window; element k=row*winCol+col at bits [k*bitwidth +: bitwidth]
- windowValid  in  1  windowIn valid
- windowReady  out  1  block can accept a window this cycle
- dataOut  out  bitwidth  current pixel
- dataValid  out  1  dataOut valid
- dataReady  in  1  consumer accepts dataOut
- startOfWindow  out  1  dataOut is element 0
- endOfRow  out  1  dataOut is the last column (col = winCol-1)
- endOfWindow  out  1  dataOut is the last element
- busy  out  1  window loaded, not fully drained

## Operation
- The FSM has two states, IDLE and SHIFT.
- A window transfer occurs when windowValid & windowReady.
- A pixel beat occurs when dataValid & dataReady & enable.
- windowReady = enable & (IDLE | (SHIFT & endOfWindow & dataReady)). This combinational path allows back-to-back windows.
- **IDLE:**
  - On a window transfer: load the shift bank from windowIn, set row=0 and col=0, and go to SHIFT.
  - dataValid = 0.
- **SHIFT:**
  - dataValid = 1 and dataOut = bank element 0.
  - On each pixel beat: shift the bank down by one element (zero fill), then col++. At col = winCol-1, set col = 0 and row++.
  - Last beat (row = winRow-1, col = winCol-1):
    - with a simultaneous window transfer: reload the bank, reset the counters, stay in SHIFT;
    - otherwise go to IDLE and clear the counters.
- Flags are decoded from registered counters and are valid only while dataValid = 1, otherwise 0:
  - startOfWindow = (row=0 & col=0)
  - endOfRow = (col = winCol-1)
  - endOfWindow = (row = winRow-1 & col = winCol-1)
- busy = SHIFT.
- Output order is row-major: element 0 first, element winRow*winCol-1 last.
- Counter widths are clog2(winCol) and clog2(winRow), minimum 1. winCol = 1 or winRow = 1 must work; with 1×1, every beat raises all three flags.
- windowIn is sampled only on a window transfer and is ignored otherwise.

## Timing
- Reset values:
  - state IDLE; bank all zeros; row = col = 0
  - dataOut = 0, dataValid = 0, all flags 0, busy = 0
  - windowReady = enable
- Latency: a window transfer at edge N gives dataValid = 1 with element 0 in the cycle after N.
- Throughput: one pixel per cycle under continuous dataReady. A window drains in winRow*winCol cycles; with back-to-back windows there are no bubbles.
- Backpressure: with dataReady low, dataOut, dataValid, flags and counters hold stable (AXI-style).
- enable low freezes all registers. windowReady is 0, and pixel beats do not complete even if dataReady is high. dataValid holds its value.
- Reset assertion mid-window immediately returns all outputs to their reset values; the partial window is discarded.
- A window offered while SHIFT is not on its last beat is not accepted; windowValid must be held by the producer.

## Structure
- A shared constants include/package holds:
  - a clog2 function;
  - numOfOutputs = winRow*winCol;
  - the IDLE/SHIFT state encodings, reused by future window-domain blocks.
- The shift bank is built per element from the existing RegisterEn-style enabled register, with a load/shift select.
- Sub-module: window_position_counter (row/col counter with wrap, increment enable, clear, and last-column/last-element outputs), reusable by other raster blocks.

## Test plan
Bench parameters: winCol=3, winRow=2, bitwidth=8.
- **Single window:** after reset release, load elements 0..5 = 0x10..0x15 with dataReady=1 → dataOut 0x10..0x15 on six consecutive cycles, starting the cycle after the transfer:
  - startOfWindow on 0x10;
  - endOfRow on 0x12 and 0x15;
  - endOfWindow on 0x15;
  - then dataValid=0 and busy=0.
- **Back-to-back:** hold windowValid with a second window 0x20..0x25 → windowReady pulses on the 0x15 beat and 0x20 follows with no gap.
- **Backpressure:** drop dataReady for 3 cycles while 0x13 is presented → 0x13 and endOfRow=0 are held, and no pixel is skipped or duplicated.
- **Enable stall:** drive enable=0 for 4 cycles mid-window with dataReady=1 → outputs frozen, windowReady=0, and the sequence resumes intact.
- **Reset mid-window:** assert reset after 0x11 → all outputs 0 asynchronously. After release, a new window 0x30..0x35 streams correctly from 0x30.
- **1×1 configuration:** load 0xAA → one beat with startOfWindow, endOfRow and endOfWindow all high.

Source files
------------

// File: rtl/window_serializer_pkg.sv
// Shared window-domain constants: width helper, element count, serializer states.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package window_serializer_pkg;

   // Two-state sequencing used by blocks that replay or collect whole windows.
   typedef enum logic {
      WIN_IDLE  = 1'b0,
      WIN_SHIFT = 1'b1
   } win_state_e;

   // Bits needed to index 'value' positions; never less than 1 so that a
   // single-position dimension still gets a real (constant-zero) counter.
   function automatic int clog2(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) begin
         w = w + 1;
      end
      return w;
   endfunction

   // Number of pixels in a win_row x win_col window.
   function automatic int num_of_outputs(input int win_row, input int win_col);
      return win_row * win_col;
   endfunction

endpackage

// File: rtl/register_en.sv
// Enabled register: captures d when en is high, otherwise holds.
// Latency: 1 cycle from d to q.
// Backpressure: none; en is the only hold control.
// Ports: clk, rst_n (async active-low, clears to zero), en, d, q.
module register_en #(
   parameter int width = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [width-1:0] d,
   output logic [width-1:0] q
);

   logic [width-1:0] data_q;
   logic [width-1:0] data_d;

   always_comb begin
      data_d = data_q;
      if (en) begin
         data_d = d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign q = data_q;

endmodule

// File: rtl/window_position_counter.sv
// Raster row/column position inside a window, wrapping at the last element.
// Latency: flags decode the registered position (valid in the same cycle).
// Backpressure: position advances only on inc; clr wins over inc.
// Ports: clk, rst_n, inc, clr, first_elem (0,0), last_col (col end), last_elem (row end & col end).
module window_position_counter
   import window_serializer_pkg::*;
#(
   parameter int num_cols = 42,
   parameter int num_rows = 42
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic first_elem,
   output logic last_col,
   output logic last_elem
);

   localparam int CW = clog2(num_cols);
   localparam int RW = clog2(num_rows);
   localparam logic [CW-1:0] COL_LAST = CW'(num_cols - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(num_rows - 1);
   localparam logic [CW-1:0] COL_ONE  = CW'(1);
   localparam logic [RW-1:0] ROW_ONE  = RW'(1);

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic          col_at_end;
   logic          row_at_end;

   assign col_at_end = (col_q == COL_LAST);
   assign row_at_end = (row_q == ROW_LAST);

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (clr) begin
         col_d = '0;
         row_d = '0;
      end else if (inc) begin
         if (col_at_end) begin
            col_d = '0;
            row_d = row_at_end ? '0 : (row_q + ROW_ONE);
         end else begin
            col_d = col_q + COL_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   assign first_elem = (row_q == '0) && (col_q == '0);
   assign last_col   = col_at_end;
   assign last_elem  = row_at_end && col_at_end;

endmodule

// File: rtl/window_serializer.sv
// Replays one parallel winRow x winCol window as a row-major pixel stream.
// Latency: element 0 appears the cycle after the window transfer; 1 pixel/cycle after.
// Backpressure: dataReady low holds pixel and flags; next window accepted only on the last beat.
// Ports: clock, reset (async active-low), enable (global stall), windowIn/windowValid/windowReady
//        (window side), dataOut/dataValid/dataReady (pixel side), startOfWindow, endOfRow,
//        endOfWindow (position flags, valid with dataValid), busy (window in flight).
module window_serializer
   import window_serializer_pkg::*;
#(
   parameter int winCol   = 42,
   parameter int winRow   = 42,
   parameter int bitwidth = 30
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              enable,
   input  logic [winRow*winCol*bitwidth-1:0] windowIn,
   input  logic                              windowValid,
   output logic                              windowReady,
   output logic [bitwidth-1:0]               dataOut,
   output logic                              dataValid,
   input  logic                              dataReady,
   output logic                              startOfWindow,
   output logic                              endOfRow,
   output logic                              endOfWindow,
   output logic                              busy
);

   localparam int NUM = num_of_outputs(winRow, winCol);

   win_state_e          state_q, state_d;
   logic                in_shift;
   logic                window_transfer;
   logic                pixel_beat;
   logic                last_beat;
   logic                pos_first;
   logic                pos_last_col;
   logic                pos_last_elem;
   logic [bitwidth-1:0] bank_q [NUM];

   assign in_shift = (state_q == WIN_SHIFT);

   // Accepting on the final beat lets the bank reload in the same edge that
   // would otherwise empty it, so consecutive windows stream without a bubble.
   assign windowReady     = enable & (~in_shift | (pos_last_elem & dataReady));
   assign window_transfer = windowValid & windowReady;
   assign pixel_beat      = in_shift & dataReady & enable;
   assign last_beat       = pixel_beat & pos_last_elem;

   always_comb begin
      state_d = state_q;
      case (state_q)
         WIN_IDLE: begin
            if (window_transfer) begin
               state_d = WIN_SHIFT;
            end
         end
         WIN_SHIFT: begin
            if (last_beat) begin
               state_d = window_transfer ? WIN_SHIFT : WIN_IDLE;
            end
         end
         default: state_d = WIN_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= WIN_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Both a reload and the natural wrap return the position to (0,0).
   window_position_counter #(
      .num_cols (winCol),
      .num_rows (winRow)
   ) u_pos (
      .clk        (clock),
      .rst_n      (reset),
      .inc        (pixel_beat),
      .clr        (window_transfer | last_beat),
      .first_elem (pos_first),
      .last_col   (pos_last_col),
      .last_elem  (pos_last_elem)
   );

   // Shift bank: element 0 is the pixel on the output. A load overrides the
   // shift; the top element fills with zero so a drained bank reads all zero.
   for (genvar k = 0; k < NUM; k++) begin : g_bank
      logic [bitwidth-1:0] elem_d;
      if (k == NUM - 1) begin : g_tail
         assign elem_d = window_transfer ? windowIn[k*bitwidth +: bitwidth] : '0;
      end else begin : g_body
         assign elem_d = window_transfer ? windowIn[k*bitwidth +: bitwidth] : bank_q[k+1];
      end
      register_en #(
         .width (bitwidth)
      ) u_elem (
         .clk   (clock),
         .rst_n (reset),
         .en    (window_transfer | pixel_beat),
         .d     (elem_d),
         .q     (bank_q[k])
      );
   end

   assign dataValid     = in_shift;
   assign dataOut       = in_shift ? bank_q[0] : '0;
   assign startOfWindow = in_shift & pos_first;
   assign endOfRow      = in_shift & pos_last_col;
   assign endOfWindow   = in_shift & pos_last_elem;
   assign busy          = in_shift;

endmodule

// File: tb/tb_window_serializer.sv
// Bench for window_serializer: 3x2x8 main instance plus a 1x1 instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_window_serializer;

   localparam int WC = 3;
   localparam int WR = 2;
   localparam int BW = 8;
   localparam int NE = WC * WR;
   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic             en;
   logic [NE*BW-1:0] win_in;
   logic             win_vld;
   logic             win_rdy;
   logic [BW-1:0]    d_out;
   logic             d_vld;
   logic             d_rdy;
   logic             sow, eor, eow, busy;

   logic [BW-1:0]    w1_in;
   logic             w1_vld, w1_rdy;
   logic [BW-1:0]    d1_out;
   logic             d1_vld, d1_rdy;
   logic             s1, r1, e1, b1;

   window_serializer #(.winCol(WC), .winRow(WR), .bitwidth(BW)) u_dut (
      .clock(clk), .reset(rst_n), .enable(en),
      .windowIn(win_in), .windowValid(win_vld), .windowReady(win_rdy),
      .dataOut(d_out), .dataValid(d_vld), .dataReady(d_rdy),
      .startOfWindow(sow), .endOfRow(eor), .endOfWindow(eow), .busy(busy)
   );

   window_serializer #(.winCol(1), .winRow(1), .bitwidth(BW)) u_dut1 (
      .clock(clk), .reset(rst_n), .enable(en),
      .windowIn(w1_in), .windowValid(w1_vld), .windowReady(w1_rdy),
      .dataOut(d1_out), .dataValid(d1_vld), .dataReady(d1_rdy),
      .startOfWindow(s1), .endOfRow(r1), .endOfWindow(e1), .busy(b1)
   );

   typedef struct packed {
      logic [BW-1:0] dat;
      logic          sow;
      logic          eor;
      logic          eow;
   } exp_t;

   typedef struct {
      logic          wv;
      logic          dr;
      logic          exp_wr;
      logic          exp_dv;
      logic [BW-1:0] exp_out;
      logic          exp_sow;
      logic          exp_eor;
      logic          exp_eow;
      logic          exp_busy;
   } vec_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [NE*BW-1:0] make_win(input logic [BW-1:0] base);
      logic [NE*BW-1:0] w;
      w = '0;
      for (int k = 0; k < NE; k++) w[k*BW +: BW] = base + BW'(k);
      return w;
   endfunction

   task automatic push_window(input logic [BW-1:0] base);
      exp_t e;
      for (int k = 0; k < NE; k++) begin
         e.dat = base + BW'(k);
         e.sow = (k == 0);
         e.eor = ((k % WC) == WC - 1);
         e.eow = (k == NE - 1);
         sb_q.push_back(e);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offers a window and waits for acceptance; returns at posedge+1 after the
   // transfer edge, so the next negedge shows element 0.
   task automatic send_window(input logic [BW-1:0] base, output int waited);
      logic ok;
      ok = 1'b0;
      waited = 0;
      win_vld = 1'b1;
      win_in = make_win(base);
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (win_rdy) begin
            push_window(base);
            ok = 1'b1;
            break;
         end
         waited++;
         step();
      end
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_window: window 0x%0h never accepted", base);
      end
      step();
      win_vld = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (!busy) break;
         step();
      end
      chk({name, "_busy"}, {31'b0, busy}, 32'd0);
      chk({name, "_sb_empty"}, sb_q.size(), 32'd0);
      step();
   endtask

   // Scoreboard: every completed pixel beat must match the oldest expected pixel.
   always @(negedge clk) begin
      if (rst_n && d_vld && d_rdy && en) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stray_beat: got 0x%0h, expected no pixel at %0t", d_out, $time);
         end else begin
            mon_e = sb_q.pop_front();
            chk("beat_dat", {24'b0, d_out}, {24'b0, mon_e.dat});
            chk("beat_flags", {29'b0, sow, eor, eow}, {29'b0, mon_e.sow, mon_e.eor, mon_e.eow});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   vec_t tbl[8];
   int   waited;

   initial begin
      tbl[0] = '{H, H, H, L, 8'h00, L, L, L, L};
      tbl[1] = '{L, H, L, H, 8'h10, H, L, L, H};
      tbl[2] = '{L, H, L, H, 8'h11, L, L, L, H};
      tbl[3] = '{L, H, L, H, 8'h12, L, H, L, H};
      tbl[4] = '{L, H, L, H, 8'h13, L, L, L, H};
      tbl[5] = '{L, H, L, H, 8'h14, L, L, L, H};
      tbl[6] = '{L, H, H, H, 8'h15, L, H, H, H};
      tbl[7] = '{L, H, H, L, 8'h00, L, L, L, L};

      rst_n = 1'b0; en = 1'b1; win_vld = 1'b0; d_rdy = 1'b1; win_in = '0;
      w1_in = '0; w1_vld = 1'b0; d1_rdy = 1'b1;

      // Reset state
      #12;
      chk("rst_wr", {31'b0, win_rdy}, 32'd1);
      chk("rst_outs", {19'b0, d_out, d_vld, sow, eor, eow, busy}, 32'd0);
      chk("rst1_outs", {19'b0, d1_out, d1_vld, s1, r1, e1, b1}, 32'd0);
      en = 1'b0;
      #1;
      chk("rst_wr_en0", {31'b0, win_rdy}, 32'd0);
      en = 1'b1;
      step();
      rst_n = 1'b1;

      // Single window, cycle by cycle
      for (int i = 0; i < 8; i++) begin
         win_vld = tbl[i].wv;
         d_rdy = tbl[i].dr;
         win_in = tbl[i].wv ? make_win(8'h10) : '0;
         if (i == 0) push_window(8'h10);
         @(negedge clk);
         chk($sformatf("t%0d_wr", i), {31'b0, win_rdy}, {31'b0, tbl[i].exp_wr});
         chk($sformatf("t%0d_dv", i), {31'b0, d_vld}, {31'b0, tbl[i].exp_dv});
         chk($sformatf("t%0d_out", i), {24'b0, d_out}, {24'b0, tbl[i].exp_out});
         chk($sformatf("t%0d_flags", i), {28'b0, sow, eor, eow, busy},
             {28'b0, tbl[i].exp_sow, tbl[i].exp_eor, tbl[i].exp_eow, tbl[i].exp_busy});
         step();
      end
      win_vld = 1'b0;
      chk("single_sb_empty", sb_q.size(), 32'd0);

      // Back-to-back windows
      send_window(8'h10, waited);
      chk("b2b_first_wait", waited, 32'd0);
      send_window(8'h20, waited);
      chk("b2b_second_wait", waited, 32'd5);
      @(negedge clk);
      chk("b2b_no_gap", {23'b0, d_vld, d_out}, {23'b0, 1'b1, 8'h20});
      step();
      drain("b2b");

      // Backpressure while 0x13 is presented
      send_window(8'h10, waited);
      step(); step(); step();
      d_rdy = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("bp%0d_hold", c), {22'b0, d_vld, eor, d_out}, {22'b0, 1'b1, 1'b0, 8'h13});
         step();
      end
      d_rdy = 1'b1;
      drain("bp");

      // Enable stall mid-window, with a competing window offered
      send_window(8'h50, waited);
      step(); step();
      en = 1'b0;
      win_vld = 1'b1;
      win_in = make_win(8'h77);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("stall%0d_out", c), {21'b0, d_vld, busy, eor, d_out},
             {21'b0, 1'b1, 1'b1, 1'b1, 8'h52});
         chk($sformatf("stall%0d_wr", c), {31'b0, win_rdy}, 32'd0);
         step();
      end
      en = 1'b1;
      win_vld = 1'b0;
      drain("stall");

      // Reset mid-window after 0x11 has gone out
      send_window(8'h10, waited);
      step(); step();
      rst_n = 1'b0;
      #1;
      chk("midrst_outs", {19'b0, d_out, d_vld, sow, eor, eow, busy}, 32'd0);
      chk("midrst_wr", {31'b0, win_rdy}, 32'd1);
      sb_q.delete();
      step();
      rst_n = 1'b1;
      send_window(8'h30, waited);
      @(negedge clk);
      chk("postrst_first", {23'b0, d_vld, d_out}, {23'b0, 1'b1, 8'h30});
      step();
      drain("postrst");

      // 1x1 configuration
      w1_vld = 1'b1;
      w1_in = 8'hAA;
      @(negedge clk);
      chk("one_wr_idle", {31'b0, w1_rdy}, 32'd1);
      step();
      w1_vld = 1'b0;
      w1_in = 8'h00;
      @(negedge clk);
      chk("one_beat", {20'b0, d1_vld, d1_out, s1, r1, e1}, {20'b0, 1'b1, 8'hAA, 3'b111});
      chk("one_wr_last", {31'b0, w1_rdy}, 32'd1);
      step();
      @(negedge clk);
      chk("one_done", {30'b0, d1_vld, b1}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
